// File: rtl/pulse_width_meter.sv
// Measures successive high/low pulse widths on an asynchronous sensor line in
// divided_clock ticks and emits one (width, level, overflow) record per finished pulse.
module pulse_width_meter #(
   parameter int COUNT_WIDTH = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   divided_clock,
   input  logic                   enable,
   input  logic                   data_in,
   output logic [COUNT_WIDTH-1:0] pulse_width,
   output logic                   pulse_level,
   output logic                   pulse_overflow,
   output logic                   pulse_valid,
   output logic                   busy
);

   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] CNT_PRE  = CNT_MAX - CNT_ONE;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 state_next_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   line_s;
   logic                   line_prev_r;
   logic                   div_prev_r;
   logic                   tick_s;
   logic                   edge_s;
   logic [COUNT_WIDTH-1:0] cnt_r;
   logic [COUNT_WIDTH-1:0] cnt_next_s;
   logic                   ovf_r;
   logic                   ovf_next_s;
   logic                   rec_fire_s;
   logic                   rec_valid_r;
   logic [COUNT_WIDTH-1:0] rec_width_r;
   logic                   rec_level_r;
   logic                   rec_ovf_r;

   assign line_s = sync_r[SYNC_STAGES-1];
   assign tick_s = divided_clock & ~div_prev_r;
   assign edge_s = line_s ^ line_prev_r;

   // Synchroniser chain plus one-clock history of line and timebase
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_r      <= {SYNC_STAGES{1'b1}};
         line_prev_r <= 1'b1;
         div_prev_r  <= 1'b0;
      end else begin
         sync_r      <= {sync_r[SYNC_STAGES-2:0], data_in};
         line_prev_r <= line_s;
         div_prev_r  <= divided_clock;
      end
   end

   // Next-state, tick counter and record trigger
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      ovf_next_s   = ovf_r;
      rec_fire_s   = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_next_s = CNT_ZERO;
            ovf_next_s = 1'b0;
            if (enable) begin
               state_next_s = ARMED;
            end else begin
               state_next_s = IDLE;
            end
         end
         ARMED: begin
            cnt_next_s = CNT_ZERO;
            ovf_next_s = 1'b0;
            if (!enable) begin
               state_next_s = IDLE;
            end else if (edge_s) begin
               state_next_s = MEASURE;
            end else begin
               state_next_s = ARMED;
            end
         end
         MEASURE: begin
            // Abort beats edge, edge beats tick: an open pulse is never reported
            if (!enable) begin
               state_next_s = IDLE;
               cnt_next_s   = CNT_ZERO;
               ovf_next_s   = 1'b0;
            end else if (edge_s) begin
               rec_fire_s = 1'b1;
               cnt_next_s = CNT_ZERO;
               ovf_next_s = 1'b0;
            end else if (tick_s && (cnt_r != CNT_MAX)) begin
               cnt_next_s = cnt_r + CNT_ONE;
               ovf_next_s = (cnt_r == CNT_PRE);
            end else begin
               cnt_next_s = cnt_r;
            end
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = CNT_ZERO;
            ovf_next_s   = 1'b0;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         ovf_r   <= 1'b0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         ovf_r   <= ovf_next_s;
      end
   end

   // Record capture stage, taken while line_prev still holds the finished level
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rec_valid_r <= 1'b0;
         rec_width_r <= CNT_ZERO;
         rec_level_r <= 1'b0;
         rec_ovf_r   <= 1'b0;
      end else begin
         rec_valid_r <= rec_fire_s;
         if (rec_fire_s) begin
            rec_width_r <= cnt_r;
            rec_level_r <= line_prev_r;
            rec_ovf_r   <= ovf_r;
         end
      end
   end

   // Registered outputs; record fields hold until the next strobe
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pulse_valid    <= 1'b0;
         pulse_width    <= CNT_ZERO;
         pulse_level    <= 1'b0;
         pulse_overflow <= 1'b0;
         busy           <= 1'b0;
      end else begin
         pulse_valid <= rec_valid_r;
         busy        <= (state_next_s != IDLE);
         if (rec_valid_r) begin
            pulse_width    <= rec_width_r;
            pulse_level    <= rec_level_r;
            pulse_overflow <= rec_ovf_r;
         end
      end
   end

endmodule
